// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control, preset and status bundle of the BCD countdown timer
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   data;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  running;
    logic                  done;

    modport master (
        output load, start, pause, data,
        input  count, tick, running, done
    );

    modport slave (
        input  load, start, pause, data,
        output count, tick, running, done
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable multi-digit BCD down-counter with prescaler, pause and expiry pulse
module bcd_countdown_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int PRE_W    = 12
) (
    input logic                  clk,
    input logic                  clear,
    bcd_countdown_timer_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    state_t           r_state, w_state_nx;
    logic [W-1:0]     r_count, w_count_nx, w_dec, w_sat;
    logic [PRE_W-1:0] r_pre, w_pre_nx;
    logic             r_tick, r_done, r_running;
    logic             w_tick_nx, w_done_nx, w_borrow, w_wrap;

    assign w_wrap      = r_pre == PRE_W'(TICK_DIV - 1);
    assign bus.count   = r_count;
    assign bus.tick    = r_tick;
    assign bus.running = r_running;
    assign bus.done    = r_done;

    // per-digit saturation of the preset and rippled-borrow decrement of the count
    always_comb begin
        w_borrow = 1'b1;
        w_sat    = '0;
        w_dec    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sat[4*i+:4] = bus.data[4*i+:4] > 4'd9 ? 4'd9 : bus.data[4*i+:4];
            w_dec[4*i+:4] = !w_borrow ? r_count[4*i+:4] :
                            r_count[4*i+:4] == 4'd0 ? 4'd9 : r_count[4*i+:4] - 4'd1;
            w_borrow      = w_borrow && r_count[4*i+:4] == 4'd0;
        end
    end

    // next state, count, prescaler and pulses; load overrides everything but clear
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_pre_nx   = r_pre;
        w_tick_nx  = 1'b0;
        w_done_nx  = 1'b0;
        if (bus.load) begin
            w_count_nx = w_sat;
            w_pre_nx   = '0;
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.pause) begin
                        w_state_nx = S_PAUSED;
                    end else if (w_wrap) begin
                        w_pre_nx   = '0;
                        w_count_nx = w_dec;
                        w_tick_nx  = 1'b1;
                        if (w_dec == '0) begin
                            w_state_nx = S_EXPIRED;
                            w_done_nx  = 1'b1;
                        end
                    end else begin
                        w_pre_nx = r_pre + 1'b1;
                    end
                end
                S_PAUSED: w_state_nx = bus.start ? S_RUN : S_PAUSED;
                default: begin
                    if (bus.start) begin
                        w_state_nx = r_count != '0 ? S_RUN : S_EXPIRED;
                        w_done_nx  = r_count == '0;
                        w_pre_nx   = '0;
                    end
                end
            endcase
        end
    end

    // state and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pre     <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_pre     <= w_pre_nx;
            r_tick    <= w_tick_nx;
            r_done    <= w_done_nx;
            r_running <= w_state_nx == S_RUN;
        end
    end
endmodule
